// File: rtl/eviction_write_buffer_pkg.sv
// Shared types for the eviction write buffer: LC-3b word/line types and FSM state encoding.
package eviction_write_buffer_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;
   typedef logic [11:0]  lc3b_line_addr;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_ACK,
      WB_RD_MEM,
      WB_DRAIN
   } wb_state_t;

   // Memory-side addresses are always line aligned.
   function automatic lc3b_word line_to_addr(input lc3b_line_addr line);
      return {line, 4'h0};
   endfunction

endpackage

// File: rtl/eviction_write_buffer_match.sv
// Combinational DEPTH-way line address comparator over the buffered entries.
module wb_match
   import eviction_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int IDX_W = $clog2(DEPTH)
)
(
   input  lc3b_line_addr    key,
   input  lc3b_line_addr    tags [DEPTH],
   input  logic [DEPTH-1:0] valid,
   output logic             hit,
   output logic [DEPTH-1:0] hit_onehot,
   output logic [IDX_W-1:0] hit_idx
);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
         assign hit_onehot[gi] = valid[gi] && (tags[gi] == key);
      end
   endgenerate

   assign hit = |hit_onehot;

   // At most one entry per line is ever valid, so OR-encoding the one-hot is exact.
   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (hit_onehot[i]) begin
            hit_idx = hit_idx | IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/eviction_write_buffer.sv
// Write buffer between the L1 line port and physical memory: absorbs writebacks,
// forwards buffered lines to reads, coalesces repeat writebacks and drains when idle.
module eviction_write_buffer
   import eviction_write_buffer_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         ca_read,
   input  logic         ca_write,
   input  logic [15:0]  ca_address,
   input  logic [127:0] ca_wdata,
   output logic [127:0] ca_rdata,
   output logic         ca_resp,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic         full,
   output logic         empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   wb_state_t        state_reg;
   logic [IDX_W-1:0] head_reg;
   logic [IDX_W-1:0] tail_reg;
   logic [CNT_W-1:0] count_reg;
   logic [DEPTH-1:0] valid_reg;
   lc3b_line_addr    tag_reg [DEPTH];
   lc3b_line         data_mem [DEPTH];
   lc3b_line         ca_rdata_reg;
   lc3b_line         pmem_wdata_reg;
   logic             pmem_read_reg;
   logic             pmem_write_reg;
   lc3b_word         pmem_address_reg;

   lc3b_line_addr    req_line;
   logic             addr_offset_unused;
   logic             match_hit;
   logic [DEPTH-1:0] match_onehot_unused;
   logic [IDX_W-1:0] match_idx;

   logic             is_idle;
   logic             wr_req;
   logic             full_int;
   logic             empty_int;
   logic             fwd_rd;
   logic             rd_miss;
   logic             wr_coalesce;
   logic             wr_alloc;
   logic             drain_start;
   logic             ram_we;
   logic [IDX_W-1:0] ram_waddr;

   assign req_line           = ca_address[15:4];
   assign addr_offset_unused = ^ca_address[3:0];

   wb_match #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_match (
      .key        (req_line),
      .tags       (tag_reg),
      .valid      (valid_reg),
      .hit        (match_hit),
      .hit_onehot (match_onehot_unused),
      .hit_idx    (match_idx)
   );

   assign full_int  = (count_reg == CNT_FULL);
   assign empty_int = (count_reg == '0);

   // Request decode is only meaningful in IDLE; read wins if both strobes are set.
   assign is_idle     = (state_reg == WB_IDLE);
   assign wr_req      = ca_write & ~ca_read;
   assign fwd_rd      = is_idle & ca_read & match_hit;
   assign rd_miss     = is_idle & ca_read & ~match_hit;
   assign wr_coalesce = is_idle & wr_req & match_hit;
   assign wr_alloc    = is_idle & wr_req & ~match_hit & ~full_int;
   assign drain_start = is_idle & ~empty_int &
                        ((wr_req & ~match_hit & full_int) | (~ca_read & ~ca_write));

   assign ram_we    = wr_coalesce | wr_alloc;
   assign ram_waddr = match_hit ? match_idx : tail_reg;

   // Line data lives in an unreset array with registered reads so it maps to block RAM.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         data_mem[ram_waddr] <= ca_wdata;
      end
      if (fwd_rd) begin
         ca_rdata_reg <= data_mem[match_idx];
      end
      if (drain_start) begin
         pmem_wdata_reg <= data_mem[head_reg];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= WB_IDLE;
         head_reg         <= '0;
         tail_reg         <= '0;
         count_reg        <= '0;
         valid_reg        <= '0;
         pmem_read_reg    <= 1'b0;
         pmem_write_reg   <= 1'b0;
         pmem_address_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_reg[i] <= '0;
         end
      end else begin
         case (state_reg)
            WB_IDLE: begin
               if (fwd_rd || wr_coalesce) begin
                  state_reg <= WB_ACK;
               end else if (wr_alloc) begin
                  tag_reg[tail_reg]   <= req_line;
                  valid_reg[tail_reg] <= 1'b1;
                  tail_reg            <= tail_reg + IDX_W'(1);
                  count_reg           <= count_reg + CNT_W'(1);
                  state_reg           <= WB_ACK;
               end else if (rd_miss) begin
                  pmem_read_reg    <= 1'b1;
                  pmem_address_reg <= line_to_addr(req_line);
                  state_reg        <= WB_RD_MEM;
               end else if (drain_start) begin
                  pmem_write_reg   <= 1'b1;
                  pmem_address_reg <= line_to_addr(tag_reg[head_reg]);
                  state_reg        <= WB_DRAIN;
               end
            end
            WB_ACK: begin
               state_reg <= WB_IDLE;
            end
            WB_RD_MEM: begin
               if (pmem_resp) begin
                  pmem_read_reg <= 1'b0;
                  state_reg     <= WB_IDLE;
               end
            end
            WB_DRAIN: begin
               // Head entry retires only once memory has committed it.
               if (pmem_resp) begin
                  pmem_write_reg      <= 1'b0;
                  valid_reg[head_reg] <= 1'b0;
                  head_reg            <= head_reg + IDX_W'(1);
                  count_reg           <= count_reg - CNT_W'(1);
                  state_reg           <= WB_IDLE;
               end
            end
            default: begin
               state_reg <= WB_IDLE;
            end
         endcase
      end
   end

   // Memory read data passes straight through so ca_resp can coincide with pmem_resp.
   assign ca_rdata     = (state_reg == WB_RD_MEM) ? pmem_rdata : ca_rdata_reg;
   assign ca_resp      = (state_reg == WB_ACK) | ((state_reg == WB_RD_MEM) & pmem_resp);
   assign pmem_read    = pmem_read_reg;
   assign pmem_write   = pmem_write_reg;
   assign pmem_address = pmem_address_reg;
   assign pmem_wdata   = pmem_wdata_reg;
   assign full         = full_int;
   assign empty        = empty_int;

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Scoreboard bench: buffer+memory must behave like a plain line memory, drains in FIFO order.
module tb_eviction_write_buffer;
   import eviction_write_buffer_pkg::*;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         ca_read, ca_write;
   logic [15:0]  ca_address;
   logic [127:0] ca_wdata, ca_rdata;
   logic         ca_resp;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;
   logic         full, empty;

   eviction_write_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .ca_read      (ca_read),
      .ca_write     (ca_write),
      .ca_address   (ca_address),
      .ca_wdata     (ca_wdata),
      .ca_rdata     (ca_rdata),
      .ca_resp      (ca_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp),
      .full         (full),
      .empty        (empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit           is_wr;
      logic [11:0]  line;
      logic [127:0] data;
   } exp_t;

   typedef struct {
      logic [11:0]  line;
      logic [127:0] data;
   } ent_t;

   exp_t         exp_q[$];
   ent_t         model_q[$];
   logic [127:0] ref_mem[bit [11:0]];
   logic [127:0] phys[bit [11:0]];

   int n_cmp = 0;
   int n_err = 0;
   bit hold = 1'b0;
   bit rand_lat = 1'b1;
   int mem_lat = 2;
   bit saw_pmem_read = 1'b0;

   function automatic logic [127:0] init_line(input logic [11:0] l);
      return {8{4'hC, l}};
   endfunction

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic void chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   function automatic void fail(input string name, input string msg);
      n_cmp++;
      n_err++;
      $display("FAIL %s: %s", name, msg);
   endfunction

   // Reference view: newest buffered copy of a line, else what memory holds.
   function automatic logic [127:0] ref_read(input logic [11:0] l);
      for (int i = 0; i < model_q.size(); i++) begin
         if (model_q[i].line == l) return model_q[i].data;
      end
      if (ref_mem.exists(l)) return ref_mem[l];
      return init_line(l);
   endfunction

   // Physical memory: responds after a latency, stalls while hold is set.
   initial begin : responder
      int wcnt;
      int tgt;
      wcnt = 0;
      tgt = 1;
      pmem_resp = 1'b0;
      pmem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (reset) begin
            pmem_resp = 1'b0;
            wcnt = 0;
         end else if (pmem_resp) begin
            pmem_resp = 1'b0;
         end else if ((pmem_read || pmem_write) && !hold) begin
            if (wcnt == 0) tgt = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
            wcnt++;
            if (wcnt >= tgt) begin
               if (pmem_write) begin
                  phys[pmem_address[15:4]] = pmem_wdata;
               end else begin
                  pmem_rdata = phys.exists(pmem_address[15:4]) ? phys[pmem_address[15:4]]
                                                                : init_line(pmem_address[15:4]);
               end
               pmem_resp = 1'b1;
               wcnt = 0;
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Monitor: checks drains against the reference FIFO and responses against the scoreboard.
   initial begin : monitor
      ent_t e;
      exp_t x;
      bit   found;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (pmem_read) saw_pmem_read = 1'b1;
            if (pmem_write && pmem_resp) begin
               if (model_q.size() == 0) begin
                  fail("drain_unexpected", $sformatf("write of %h with empty reference buffer", pmem_address));
               end else begin
                  e = model_q.pop_front();
                  chk("drain_addr", {112'd0, pmem_address}, {112'd0, e.line, 4'h0});
                  chk("drain_data", pmem_wdata, e.data);
                  ref_mem[e.line] = e.data;
               end
            end
            if (pmem_read && pmem_resp) chk("rd_resp_with_pmem_resp", {127'd0, ca_resp}, 128'd1);
            if (ca_resp) begin
               if (exp_q.size() == 0) begin
                  fail("spurious_resp", "ca_resp with no outstanding request");
               end else begin
                  x = exp_q.pop_front();
                  if (x.is_wr) begin
                     found = 1'b0;
                     for (int i = 0; i < model_q.size(); i++) begin
                        if (model_q[i].line == x.line) begin
                           model_q[i].data = x.data;
                           found = 1'b1;
                        end
                     end
                     if (!found) begin
                        if (model_q.size() < DEPTH) begin
                           e.line = x.line;
                           e.data = x.data;
                           model_q.push_back(e);
                        end else begin
                           fail("wr_overflow", $sformatf("write %h acked while %0d lines buffered", x.line, model_q.size()));
                        end
                     end
                  end else begin
                     chk($sformatf("rd_data_%h", x.line), ca_rdata, x.data);
                  end
               end
            end
         end
      end
   end

   // Issue one request at posedge+1 and hold it until ca_resp; lat counts negedges up to the response.
   task automatic req(input bit wr, input logic [15:0] addr, input logic [127:0] wdata, output int lat);
      exp_t x;
      x.is_wr = wr;
      x.line  = addr[15:4];
      x.data  = wr ? wdata : ref_read(addr[15:4]);
      exp_q.push_back(x);
      ca_address = addr;
      ca_wdata   = wr ? wdata : {4{$urandom()}};
      ca_read    = !wr;
      ca_write   = wr;
      lat = 0;
      forever begin
         @(negedge clk);
         lat++;
         if (ca_resp) break;
         if (lat >= 500) begin
            fail("req_timeout", $sformatf("no ca_resp for addr %h", addr));
            break;
         end
      end
      @(posedge clk);
      #1;
      ca_read  = 1'b0;
      ca_write = 1'b0;
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (!(empty && !pmem_write && exp_q.size() == 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) fail("drain_timeout", "buffer did not empty");
      chk_int("model_drained", model_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ca_resp"}, {127'd0, ca_resp}, 128'd0);
      chk({tag, "_pmem_read"}, {127'd0, pmem_read}, 128'd0);
      chk({tag, "_pmem_write"}, {127'd0, pmem_write}, 128'd0);
      chk({tag, "_pmem_address"}, {112'd0, pmem_address}, 128'd0);
      chk({tag, "_empty"}, {127'd0, empty}, 128'd1);
      chk({tag, "_full"}, {127'd0, full}, 128'd0);
   endtask

   initial begin : stim
      int lat;
      logic [127:0] d1, d2, dx;
      logic [11:0]  line;
      ca_read = 1'b0;
      ca_write = 1'b0;
      ca_address = '0;
      ca_wdata = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;
      d1 = {4{$urandom()}};
      d2 = {4{$urandom()}};

      // Single write is acked on the second cycle, then drains on its own.
      hold = 1'b1;
      req(1'b1, 16'h1230, d1, lat);
      chk_int("wr_latency", lat, 2);
      chk("wr_not_empty", {127'd0, empty}, 128'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("drain_strobe", {127'd0, pmem_write}, 128'd1);
      chk("drain_addr_early", {112'd0, pmem_address}, {112'd0, 16'h1230});
      chk("drain_wdata_early", pmem_wdata, d1);
      hold = 1'b0;
      wait_empty();

      // Read of a buffered line is forwarded without touching memory.
      hold = 1'b1;
      saw_pmem_read = 1'b0;
      req(1'b1, 16'h1230, d1, lat);
      req(1'b0, 16'h1238, '0, lat);
      chk_int("fwd_latency", lat, 2);
      chk("fwd_no_pmem_read", {127'd0, saw_pmem_read}, 128'd0);
      hold = 1'b0;
      wait_empty();

      // Repeat writeback to one line coalesces into a single drain of the newest data.
      hold = 1'b1;
      req(1'b1, 16'h4560, d1, lat);
      req(1'b1, 16'h4564, d2, lat);
      repeat (2) @(posedge clk);
      #1;
      chk("coalesce_wdata", pmem_wdata, d2);
      hold = 1'b0;
      wait_empty();

      // Fill, then a fifth write must wait for the head drain.
      hold = 1'b1;
      for (int i = 1; i <= 4; i++) req(1'b1, 16'(i) << 12, {4{$urandom()}}, lat);
      chk("fill_full", {127'd0, full}, 128'd1);
      fork
         req(1'b1, 16'h5000, {4{$urandom()}}, lat);
         begin
            repeat (8) @(negedge clk);
            chk_int("full_write_stalled", exp_q.size(), 1);
            hold = 1'b0;
         end
      join
      wait_empty();

      // Miss goes to memory; ca_resp coincides with pmem_resp after 3 cycles.
      rand_lat = 1'b0;
      mem_lat = 3;
      saw_pmem_read = 1'b0;
      req(1'b0, 16'h7770, '0, lat);
      chk_int("miss_latency", lat, 4);
      chk("miss_used_pmem", {127'd0, saw_pmem_read}, 128'd1);
      rand_lat = 1'b1;

      // Reset mid-drain discards the buffered line.
      hold = 1'b1;
      dx = {4{$urandom()}};
      req(1'b1, 16'h6660, dx, lat);
      repeat (3) @(posedge clk);
      #1;
      chk("pre_reset_draining", {127'd0, pmem_write}, 128'd1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_drain_reset");
      model_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      hold = 1'b0;
      saw_pmem_read = 1'b0;
      req(1'b0, 16'h6660, '0, lat);
      chk("discarded_line_from_pmem", {127'd0, saw_pmem_read}, 128'd1);
      wait_empty();

      // Random mix over a small line set to exercise hits, coalescing, stalls and drains.
      for (int n = 0; n < 400; n++) begin
         line = 12'h100 + 12'($urandom_range(0, 7));
         req($urandom_range(0, 1) == 1, {line, 4'($urandom())}, {4{$urandom()}}, lat);
         repeat ($urandom_range(0, 4)) @(posedge clk);
         #1;
      end
      wait_empty();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/eviction_write_buffer.md
Name: eviction_write_buffer

Overview:
- Sits directly downstream of the L1 cache datapath, between the cache's 128-bit line port (mem_address/mem_wdata/mem_rdata) and physical memory.
- Absorbs dirty-line writebacks into a small FIFO so the cache's allocate read is not blocked behind the eviction.
- Forwards buffered lines to subsequent cache line reads, coalesces repeat writebacks to the same line, and drains to memory whenever memory is otherwise idle.

Parameters:
DEPTH, 4, number of 128-bit line entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ca_read  input  1  cache line read request; held until ca_resp
ca_write  input  1  cache line writeback request; held until ca_resp
ca_address  input  16 (lc3b_word)  line address; bits [3:0] ignored
ca_wdata  input  128  writeback line data
ca_rdata  output  128  read line data, valid while ca_resp=1
ca_resp  output  1  one-cycle completion pulse to cache
pmem_read  output  1  physical memory read strobe
pmem_write  output  1  physical memory write strobe
pmem_address  output  16  line-aligned address ({tag,index,4'h0})
pmem_wdata  output  128  drain data
pmem_rdata  input  128  memory read data
pmem_resp  input  1  memory completion
full  output  1  occupancy == DEPTH (debug/perf)
empty  output  1  occupancy == 0

Behaviour:
- Reset (async, immediate): state=IDLE; head=tail=count=0; all valid bits cleared; ca_resp, pmem_read, pmem_write = 0; pmem_address = 0; empty=1, full=0. Reset mid-drain discards all buffered data, and the in-flight pmem access is dropped.
- Entry: {valid, line_addr[11:0] = addr[15:4], data[127:0]}. At most one valid entry per line_addr at any time.
- Match: line_addr compared against all valid entries, combinationally.
- ca_read and ca_write never assert together (cache controller guarantee). If they do, read takes priority.
- FSM states: IDLE, ACK, RD_MEM, DRAIN.
- IDLE, ca_write, match on a non-head entry (or on the head while not draining): overwrite that entry's data in place (coalesce) -> ACK. Count unchanged.
- IDLE, ca_write, no match, !full: write entry at tail, tail++, count++ -> ACK.
- IDLE, ca_write, no match, full: no accept; start a drain of the head -> DRAIN. The write is re-evaluated on return to IDLE.
- IDLE, ca_read, match: register the entry's data into ca_rdata -> ACK. Latency = 2 cycles from request to ca_resp.
- IDLE, ca_read, no match -> RD_MEM.
- IDLE, no request, !empty -> DRAIN with head entry.
- ACK: ca_resp=1 for exactly one cycle -> IDLE. The cache drops its request in the same cycle, so the request is not re-serviced.
- RD_MEM: pmem_read=1, pmem_address = {ca_address[15:4],4'h0}. On pmem_resp: ca_resp=1 in the same cycle, ca_rdata = pmem_rdata (combinational pass) -> IDLE.
- DRAIN: pmem_write=1, pmem_address/pmem_wdata taken from the head entry, held stable. On pmem_resp: clear head valid, head++, count-- -> IDLE.
- A drain in progress is never preempted. Reads arriving during DRAIN wait in IDLE order (read priority applies only at IDLE).
- Pointers wrap modulo DEPTH.
- full/empty are derived from count (width clog2(DEPTH)+1), not from pointer compare.
- Writes never go to pmem directly; every writeback passes through the buffer.

Decomposition:
- lc3b_types additions: lc3b_line (logic [127:0]); lc3b_line_addr (logic [11:0]); enum wb_state_t {WB_IDLE, WB_ACK, WB_RD_MEM, WB_DRAIN}.
- Sub-module wb_match: combinational DEPTH-way line_addr comparator. Outputs hit and a one-hot/encoded index.
- FIFO storage, pointers and FSM stay in the top module.

Test Plan:
1. Reset, then ca_write addr 0x1230 data D1 -> ca_resp at cycle 2; count=1. Then idle -> pmem_write with address 0x1230, data D1; after pmem_resp, empty=1.
2. Hold pmem_resp low; write 0x1230 D1, then ca_read 0x1238 -> ca_rdata=D1 and ca_resp 2 cycles after the read request; no pmem_read asserted.
3. Write 0x4560 D1, then write 0x4560 D2 before any drain -> count stays 1; the single drain carries D2.
4. Fill DEPTH=4 with 0x1000, 0x2000, 0x3000, 0x4000, then write 0x5000 -> no ca_resp until the drain of 0x1000 gets pmem_resp; then 0x5000 is accepted; FIFO drain order is 0x2000, 0x3000, 0x4000, 0x5000.
5. Buffer empty, ca_read 0x7770; memory returns R after 3 cycles -> ca_resp coincides with pmem_resp and ca_rdata=R.
6. Assert reset mid-DRAIN -> pmem_write and ca_resp drop immediately, empty=1; a subsequent ca_read to the discarded line goes to pmem.
